gpo_pad_ctrl: RTL
=================

Name: gpo_pad_ctrl

Overview:
Sequencing controller for a single general-purpose output pad (DO/DS/SR/CO/OE/ODP/ODN pins).
- Accepts configuration updates over a valid/ready handshake and applies them glitch-free: output is disabled, settle time elapses, new settings load, then output re-enables.
- Guards nonzero drive strengths against a missing bias supply (vbias_ok_i), falling back to DS=00 and flagging an error.
- Sits between the pad-config register block and the pad cell.

Parameters:
SETTLE_CYCLES, 4, cycles OE held low before new config loads; legal range 1..2^CNT_W-1
BIAS_TIMEOUT, 255, max cycles to wait for vbias_ok_i after applying DS!=00; legal range 1..2^CNT_W-1
CNT_W, 8, width of shared settle/timeout counter

Ports:
clk  in  1  single clock
rst  in  1  reset; synchronous, active-high
cfg_valid_i  in  1  new configuration offered
cfg_ready_o  out  1  controller can accept configuration
cfg_ds_i  in  2  requested drive strength
cfg_sr_i  in  1  requested slew-rate select
cfg_co_i  in  1  requested CO control
cfg_mode_i  in  2  bit0 -> ODP (disable high side), bit1 -> ODN (disable low side); 00 push-pull, 01 open-drain, 10 open-source, 11 hi-Z
cfg_oe_i  in  1  requested output enable
data_i  in  1  output data
vbias_ok_i  in  1  bias supply valid (required for DS!=00)
err_clr_i  in  1  clears err_bias_o
do_o  out  1  to pad DO_I
ds_o  out  2  to pad DS_I
sr_o  out  1  to pad SR_I
co_o  out  1  to pad CO_I
oe_o  out  1  to pad OE_I
odp_o  out  1  to pad ODP_I
odn_o  out  1  to pad ODN_I
busy_o  out  1  state != ACTIVE
err_bias_o  out  1  sticky: bias fallback occurred

Behaviour:
- All outputs registered.
- Reset values: do_o=0, ds_o=00, sr_o=0, co_o=0, oe_o=0, odp_o=0, odn_o=0, err_bias_o=0; state ACTIVE; counter 0.
- rst asserted mid-sequence aborts immediately to reset values; any pending shadow config is discarded.
- do_o <= data_i every cycle, in all states: 1-cycle latency.
- Bias fault: fault = (state==ACTIVE) && ds_o!=00 && !vbias_ok_i.
- Ready: cfg_ready_o = (state==ACTIVE) && !fault (combinational). A transfer occurs when cfg_valid_i && cfg_ready_o; the inputs are captured into the shadow config.
- States:
  - ACTIVE: outputs stable.
    - Transfer at cycle T -> DRAIN at T+1.
    - On fault: shadow <= current config with ds forced 00; err_bias_o <= 1; -> DRAIN. The fault has priority over a simultaneous cfg_valid_i, which is not accepted.
  - DRAIN: oe_o=0 from T+1. Counter runs SETTLE_CYCLES cycles (T+1..T+S), then -> APPLY.
  - APPLY (T+S+1): ds_o/sr_o/co_o/odp_o/odn_o show shadow values; oe_o still 0.
    - If shadow ds==00 or vbias_ok_i -> ACTIVE, with oe_o=shadow oe visible at T+S+2.
    - Otherwise -> BIAS_WAIT, counter cleared.
  - BIAS_WAIT: oe_o=0.
    - vbias_ok_i=1 -> ACTIVE next cycle with oe_o=shadow oe.
    - After BIAS_TIMEOUT cycles without vbias_ok_i: ds_o <= 00, err_bias_o <= 1, -> ACTIVE with oe_o=shadow oe.
- oe_o is never 1 in the same cycle any of ds/sr/co/odp/odn changes (break-before-make invariant).
- err_bias_o is cleared by err_clr_i. If a set and a clear occur in the same cycle, the set wins.
- Back-to-back configs: the next transfer is accepted only once ACTIVE is re-entered; minimum spacing is SETTLE_CYCLES+2 cycles.

Test Plan:
- Reset, then cfg {ds=00, mode=00, oe=1} at T with S=4 -> ready low T+1..T+5; oe_o=0 T+1..T+5; oe_o=1 at T+6; do_o tracks data_i with 1-cycle delay throughout.
- cfg ds=10, vbias_ok_i=1 -> ds_o=10 at T+5, oe_o=1 at T+6, err_bias_o=0; check oe_o is low in every cycle where ds_o changes.
- cfg ds=11 with vbias_ok_i=0, rises 10 cycles after APPLY -> BIAS_WAIT, oe_o=1 the cycle after the rise; with vbias_ok_i held 0 (BIAS_TIMEOUT=255) -> ds_o=00, err_bias_o=1, oe_o=1.
- ACTIVE with ds_o=01, drop vbias_ok_i while offering cfg_valid_i -> ready=0, cfg not accepted, err_bias_o=1, drain then ds_o=00 with other fields unchanged.
- Assert rst during DRAIN -> next cycle all outputs at reset values, ready=1; err_clr_i clears the sticky flag; simultaneous set+clear leaves err_bias_o=1.
- mode 01/10/11 sequences -> (odp_o,odn_o) = (1,0)/(0,1)/(1,1) applied only while oe_o=0.

Source files
------------

// File: rtl/gpo_pad_ctrl.sv
// Sequencing controller for one general-purpose output pad: applies new pad
// settings break-before-make and falls back to DS=00 when the bias supply is missing.
module gpo_pad_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BIAS_TIMEOUT  = 255,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [1:0] cfg_ds_i,
  input  logic       cfg_sr_i,
  input  logic       cfg_co_i,
  input  logic [1:0] cfg_mode_i,
  input  logic       cfg_oe_i,
  input  logic       data_i,
  input  logic       vbias_ok_i,
  input  logic       err_clr_i,
  output logic       do_o,
  output logic [1:0] ds_o,
  output logic       sr_o,
  output logic       co_o,
  output logic       oe_o,
  output logic       odp_o,
  output logic       odn_o,
  output logic       busy_o,
  output logic       err_bias_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_APPLY,
    ST_BIAS_WAIT
  } state_t;

  typedef struct packed {
    logic [1:0] ds;
    logic       sr;
    logic       co;
    logic [1:0] mode;
    logic       oe;
  } pad_cfg_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIAS_LAST   = CNT_W'(BIAS_TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  pad_cfg_t         r_sh, w_sh_nxt;

  logic       r_do;
  logic [1:0] r_ds, w_ds_nxt;
  logic       r_sr, w_sr_nxt;
  logic       r_co, w_co_nxt;
  logic       r_oe, w_oe_nxt;
  logic       r_odp, w_odp_nxt;
  logic       r_odn, w_odn_nxt;
  logic       r_busy;
  logic       r_err, w_err_nxt;
  logic       w_err_set;

  logic       w_fault;
  logic       w_xfer;

  assign w_fault     = (r_state == ST_ACTIVE) && (r_ds != 2'b00) && !vbias_ok_i;
  assign cfg_ready_o = (r_state == ST_ACTIVE) && !w_fault;
  assign w_xfer      = cfg_valid_i && cfg_ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_ds_nxt    = r_ds;
    w_sr_nxt    = r_sr;
    w_co_nxt    = r_co;
    w_oe_nxt    = r_oe;
    w_odp_nxt   = r_odp;
    w_odn_nxt   = r_odn;
    w_err_set   = 1'b0;

    unique case (r_state)
      ST_ACTIVE: begin
        // A bias fault outranks a pending request: re-apply what is on the pad with DS dropped.
        if (w_fault) begin
          w_sh_nxt.ds   = 2'b00;
          w_sh_nxt.sr   = r_sr;
          w_sh_nxt.co   = r_co;
          w_sh_nxt.mode = {r_odn, r_odp};
          w_sh_nxt.oe   = r_oe;
          w_err_set     = 1'b1;
          w_oe_nxt      = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_DRAIN;
        end else if (w_xfer) begin
          w_sh_nxt.ds   = cfg_ds_i;
          w_sh_nxt.sr   = cfg_sr_i;
          w_sh_nxt.co   = cfg_co_i;
          w_sh_nxt.mode = cfg_mode_i;
          w_sh_nxt.oe   = cfg_oe_i;
          w_oe_nxt      = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        w_oe_nxt = 1'b0;
        if (r_cnt == SETTLE_LAST) begin
          w_ds_nxt    = r_sh.ds;
          w_sr_nxt    = r_sh.sr;
          w_co_nxt    = r_sh.co;
          w_odp_nxt   = r_sh.mode[0];
          w_odn_nxt   = r_sh.mode[1];
          w_state_nxt = ST_APPLY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_APPLY: begin
        w_oe_nxt = 1'b0;
        if ((r_sh.ds == 2'b00) || vbias_ok_i) begin
          w_oe_nxt    = r_sh.oe;
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_BIAS_WAIT;
        end
      end

      ST_BIAS_WAIT: begin
        w_oe_nxt = 1'b0;
        if (vbias_ok_i) begin
          w_oe_nxt    = r_sh.oe;
          w_state_nxt = ST_ACTIVE;
        end else if (r_cnt == BIAS_LAST) begin
          // DS drops while OE is still low; APPLY then re-enables one cycle later.
          w_ds_nxt    = 2'b00;
          w_sh_nxt.ds = 2'b00;
          w_err_set   = 1'b1;
          w_state_nxt = ST_APPLY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_oe_nxt    = 1'b0;
        w_state_nxt = ST_ACTIVE;
      end
    endcase

    w_err_nxt = w_err_set | (r_err & ~err_clr_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACTIVE;
      r_cnt   <= '0;
      r_do    <= 1'b0;
      r_ds    <= 2'b00;
      r_sr    <= 1'b0;
      r_co    <= 1'b0;
      r_oe    <= 1'b0;
      r_odp   <= 1'b0;
      r_odn   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_do    <= data_i;
      r_ds    <= w_ds_nxt;
      r_sr    <= w_sr_nxt;
      r_co    <= w_co_nxt;
      r_oe    <= w_oe_nxt;
      r_odp   <= w_odp_nxt;
      r_odn   <= w_odn_nxt;
      r_busy  <= (w_state_nxt != ST_ACTIVE);
      r_err   <= w_err_nxt;
    end
  end

  // Shadow is only read after a fresh capture, so it needs no reset.
  always_ff @(posedge clk) begin
    r_sh <= w_sh_nxt;
  end

  assign do_o       = r_do;
  assign ds_o       = r_ds;
  assign sr_o       = r_sr;
  assign co_o       = r_co;
  assign oe_o       = r_oe;
  assign odp_o      = r_odp;
  assign odn_o      = r_odn;
  assign busy_o     = r_busy;
  assign err_bias_o = r_err;

endmodule
